// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the four-way round-robin arbiter.
//   - arb_state_e : FSM state encoding (IDLE / GRANT)
//   - DEF_MAX_HOLD / DEF_CW : default hold limit and hold-counter width
//   - win_t / next_winner : rotate-and-priority-encode search over four
//     requesters starting at a pointer, with an exclude mask
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_MAX_HOLD = 8;
  localparam int DEF_CW       = 4;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } win_t;

  // Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set bit wins.
  // Walking the offsets from highest to lowest lets the lowest offset
  // overwrite the result last, so it takes priority.
  function automatic win_t next_winner(input logic [3:0] req,
                                       input logic [1:0] ptr,
                                       input logic [3:0] excl);
    win_t       w;
    logic [3:0] m;
    logic [1:0] c;
    w = '0;
    m = req & ~excl;
    for (int k = 3; k >= 0; k--) begin
      c = ptr + 2'(k);
      if (m[c]) begin
        w.found = 1'b1;
        w.idx   = c;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/arbiter_rr4_dec.sv
// Decoder2_4: 2-to-4 one-hot decoder with enable.
//   w_i  [1:0] : select index
//   en_i       : enable; output is all-zero when low
//   y_o  [3:0] : one-hot output, bit w_i set when enabled
module Decoder2_4 (
  input  logic [1:0] w_i,
  input  logic       en_i,
  output logic [3:0] y_o
);

  always_comb begin
    y_o = 4'b0000;
    if (en_i) begin
      y_o[w_i] = 1'b1;
    end
  end

endmodule

// File: rtl/arbiter_rr4.sv
// arbiter_rr4: round-robin arbiter sharing one resource among four
// requesters. A grant is held while its requester keeps req high, up to
// MAX_HOLD cycles; after that the holder is rotated out if anyone else is
// waiting. Handovers (release or expiry) happen on a single edge.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   req  [3:0] : request vector, bit i = requester i
//   gnt  [3:0] : one-hot grant, zero when no grant is held
//   gnt_idx    : registered index of the current grantee
//   gnt_valid  : registered, high while a grant is held
//   preempt    : registered one-cycle pulse after a forced rotation
module arbiter_rr4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CW       = DEF_CW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  arb_state_e    state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          preempt_q;

  logic [3:0]    hold_mask;
  win_t          win_any;
  win_t          win_oth;

  // The holder is excluded from the search used in GRANT; on a release its
  // req bit is already low, so the same search serves both handover cases.
  always_comb begin
    hold_mask = 4'b0001 << idx_q;
    win_any   = next_winner(req, ptr_q, 4'b0000);
    win_oth   = next_winner(req, ptr_q, hold_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_any.found) begin
            state_q <= ST_GRANT;
            idx_q   <= win_any.idx;
            ptr_q   <= win_any.idx + 2'd1;
            cnt_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (!req[idx_q]) begin
            // Release wins over a coincident expiry, so no preempt here.
            if (win_oth.found) begin
              idx_q <= win_oth.idx;
              ptr_q <= win_oth.idx + 2'd1;
              cnt_q <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (cnt_q == HOLD_LAST) begin
            // Expired: rotate only if someone else waits; otherwise keep the
            // grant with the counter parked at its last value.
            if (win_oth.found) begin
              idx_q     <= win_oth.idx;
              ptr_q     <= win_oth.idx + 2'd1;
              cnt_q     <= '0;
              preempt_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == ST_GRANT);
  assign preempt   = preempt_q;

  Decoder2_4 u_dec (
    .w_i  (idx_q),
    .en_i (gnt_valid),
    .y_o  (gnt)
  );

endmodule

// File: tb/tb_arbiter_rr4.sv
module tb_arbiter_rr4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int total;
  int bad;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       pre;
    logic       idx_care;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  arbiter_rr4 #(.MAX_HOLD(8), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic exp_t mk(input logic [3:0] g, input logic pre,
                              input logic idx_care, input string tag);
    exp_t e;
    e.gnt      = g;
    e.idx      = enc(g);
    e.vld      = (g != 4'b0000);
    e.pre      = pre;
    e.idx_care = idx_care | (g != 4'b0000);
    e.tag      = tag;
    return e;
  endfunction

  task automatic check_front();
    exp_t       e;
    logic [7:0] obs;
    logic [7:0] want;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty: observed=empty required=entry");
      return;
    end
    e    = sbq.pop_front();
    obs  = {gnt, (e.idx_care ? gnt_idx : 2'b00), gnt_valid, preempt};
    want = {e.gnt, (e.idx_care ? e.idx : 2'b00), e.vld, e.pre};
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed gnt/idx/vld/pre=%b required=%b", e.tag, obs, want);
    end
  endtask

  // Drive req for one edge; expected outputs after that edge.
  task automatic step(input logic [3:0] r, input logic [3:0] g,
                      input logic pre, input string tag);
    @(negedge clk);
    req = r;
    sbq.push_back(mk(g, pre, 1'b0, tag));
    @(posedge clk);
    #1;
    check_front();
  endtask

  // Check the current (reset) state without waiting for an edge.
  task automatic check_reset(input string tag);
    sbq.push_back(mk(4'b0000, 1'b0, 1'b1, tag));
    check_front();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b0;
    #2;
    check_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    req   = 4'b0000;
    rst_n = 1'b0;
    #2;
    check_reset("reset_initial");
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, then drop.
    step(4'b0100, 4'b0100, 1'b0, "single_grant");
    step(4'b0000, 4'b0000, 1'b0, "single_release");
    step(4'b0000, 4'b0000, 1'b0, "single_idle");

    // Fairness: each holder keeps req for 2 cycles then drops it.
    do_reset("reset_before_fair");
    step(4'b1111, 4'b0001, 1'b0, "fair_first");
    for (int h = 0; h < 4; h++) begin
      step(4'b1111, 4'b0001 << h, 1'b0, "fair_hold");
      step(4'b1111 & ~(4'b0001 << h), 4'b0001 << ((h + 1) % 4), 1'b0, "fair_handover");
    end
    step(4'b1111, 4'b0001, 1'b0, "fair_wrap_hold");
    step(4'b0000, 4'b0000, 1'b0, "fair_release");

    // Preemption with constant contention between 0 and 1.
    do_reset("reset_before_preempt");
    for (int i = 0; i < 8; i++) step(4'b0011, 4'b0001, 1'b0, "preempt_hold0");
    step(4'b0011, 4'b0010, 1'b1, "preempt_rot_to1");
    for (int i = 0; i < 7; i++) step(4'b0011, 4'b0010, 1'b0, "preempt_hold1");
    step(4'b0011, 4'b0001, 1'b1, "preempt_rot_to0");
    step(4'b0000, 4'b0000, 1'b0, "preempt_release");

    // Saturation: lone requester 3, then requester 0 joins.
    for (int i = 0; i < 20; i++) step(4'b1000, 4'b1000, 1'b0, "sat_hold3");
    step(4'b1001, 4'b0001, 1'b1, "sat_switch_to0");
    step(4'b0000, 4'b0000, 1'b0, "sat_release");

    // Release on the same edge as expiry, plus non-holder req noise.
    do_reset("reset_before_relexp");
    for (int i = 0; i < 8; i++) step(4'b0011, 4'b0001, 1'b0, "relexp_hold0");
    step(4'b0010, 4'b0010, 1'b0, "relexp_handover");
    step(4'b0110, 4'b0010, 1'b0, "nonholder_noise_a");
    step(4'b0010, 4'b0010, 1'b0, "nonholder_noise_b");
    step(4'b0000, 4'b0000, 1'b0, "relexp_release");

    // Reset asserted between edges while requester 2 holds.
    do_reset("reset_before_mid");
    step(4'b0100, 4'b0100, 1'b0, "mid_grant2");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset_async");
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0101, 4'b0001, 1'b0, "mid_after_reset");
    step(4'b0000, 4'b0000, 1'b0, "mid_release");

    total++;
    assert (sbq.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d required=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
